// File: rtl/warp_fetch_scheduler.sv
// warp_fetch_scheduler
//   Initiator side of the per-warp fetch handshake. Every cycle one ready warp
//   is picked round-robin. Its selected-for-fetch line is pulsed in the same
//   cycle, and {pc, warp id} is loaded into a one-entry request register that
//   feeds instruction memory with a valid/ready handshake. An in-flight credit
//   counter limits how many fetches can be outstanding before the decoder
//   retires them.
//
// Ports
//   clk_i             clock; all state changes on the rising edge
//   rst_i             synchronous reset, active-high
//   warp_ready_i      per-warp ready-for-fetch
//   warp_pc_i         per-warp fetch PC; warp w sits at [w*PcWidth +: PcWidth]
//   warp_selected_o   one-hot grant pulse (combinational)
//   imem_req_valid_o  fetch request valid (registered)
//   imem_req_ready_i  instruction memory accepts the request
//   imem_req_pc_o     fetch PC (registered)
//   imem_req_warp_o   warp id of the request (registered)
//   decode_done_i     decoder retired one fetched instruction (frees a credit)
//   inflight_o        current in-flight count (debug)
module warp_fetch_scheduler #(
    parameter int NumWarps    = 8,
    parameter int PcWidth     = 32,
    parameter int MaxInflight = 4,
    // Derived from NumWarps; not meant to be overridden.
    parameter int WarpIdWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumWarps-1:0]              warp_ready_i,
    input  logic [NumWarps*PcWidth-1:0]      warp_pc_i,
    output logic [NumWarps-1:0]              warp_selected_o,
    output logic                             imem_req_valid_o,
    input  logic                             imem_req_ready_i,
    output logic [PcWidth-1:0]               imem_req_pc_o,
    output logic [WarpIdWidth-1:0]           imem_req_warp_o,
    input  logic                             decode_done_i,
    output logic [$clog2(MaxInflight+1)-1:0] inflight_o
);

    localparam int CntW = $clog2(MaxInflight + 1);

    logic [WarpIdWidth-1:0] rr_ptr_reg;
    logic                   valid_reg;
    logic [PcWidth-1:0]     pc_reg;
    logic [WarpIdWidth-1:0] warp_reg;
    logic [CntW-1:0]        inflight_reg;

    logic [PcWidth-1:0]     pc_arr [NumWarps];
    logic                   found;
    logic [WarpIdWidth-1:0] winner;
    int                     idx;
    logic                   slot_free;
    logic                   credit_ok;
    logic                   grant;

    // Unpack the flat PC bus into one entry per warp.
    generate
        for (genvar gi = 0; gi < NumWarps; gi++) begin : g_pc_unpack
            assign pc_arr[gi] = warp_pc_i[gi*PcWidth +: PcWidth];
        end
    endgenerate

    // Round-robin search: the first ready warp starting at rr_ptr and wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NumWarps; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NumWarps;
            if (!found && warp_ready_i[idx]) begin
                found  = 1'b1;
                winner = WarpIdWidth'(idx);
            end
        end
    end

    // The request register can be reloaded in the same cycle it is accepted.
    assign slot_free = !valid_reg || imem_req_ready_i;
    // Credits are checked against the registered count only. A decode_done in
    // the same cycle does not free a credit until the next cycle.
    assign credit_ok = inflight_reg < CntW'(MaxInflight);
    assign grant     = !rst_i && slot_free && credit_ok && found;

    always_comb begin
        warp_selected_o = '0;
        if (grant) begin
            warp_selected_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg   <= '0;
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            warp_reg     <= '0;
            inflight_reg <= '0;
        end else begin
            if (grant) begin
                valid_reg  <= 1'b1;
                pc_reg     <= pc_arr[winner];
                warp_reg   <= winner;
                rr_ptr_reg <= (winner == WarpIdWidth'(NumWarps - 1)) ? '0 : winner + 1'b1;
            end else if (imem_req_ready_i) begin
                valid_reg <= 1'b0;
            end

            // Grant and retire in the same cycle cancel out. The decrement is
            // guarded so an illegal retire at zero cannot wrap the counter.
            if (grant && !decode_done_i) begin
                inflight_reg <= inflight_reg + 1'b1;
            end else if (!grant && decode_done_i && inflight_reg != '0) begin
                inflight_reg <= inflight_reg - 1'b1;
            end
        end
    end

    assign imem_req_valid_o = valid_reg;
    assign imem_req_pc_o    = pc_reg;
    assign imem_req_warp_o  = warp_reg;
    assign inflight_o       = inflight_reg;

    // Interface checks.
    a_sel_onehot0 : assert property (@(posedge clk_i) $onehot0(warp_selected_o));
    a_sel_ready   : assert property (@(posedge clk_i) (warp_selected_o & ~warp_ready_i) == '0);
    a_req_stable  : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_reg && !imem_req_ready_i) |=> (valid_reg && $stable(pc_reg) && $stable(warp_reg)));
    a_inflight_max : assert property (@(posedge clk_i) inflight_reg <= CntW'(MaxInflight));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(decode_done_i && inflight_reg == '0));

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler (NumWarps=8, PcWidth=32, MaxInflight=4).
// Inputs change 1 ns after a rising edge. Combinational grants are sampled 1 ns
// after that. Registered outputs are sampled 1 ns after the edge.
module tb_warp_fetch_scheduler;

    localparam int NW = 8;
    localparam int PW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NW-1:0]   warp_ready_i;
    logic [NW*PW-1:0] warp_pc_i;
    logic [NW-1:0]   warp_selected_o;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [PW-1:0]   imem_req_pc_o;
    logic [2:0]      imem_req_warp_o;
    logic            decode_done_i;
    logic [2:0]      inflight_o;

    int tests_run    = 0;
    int tests_failed = 0;

    warp_fetch_scheduler #(
        .NumWarps(NW),
        .PcWidth(PW),
        .MaxInflight(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .warp_ready_i(warp_ready_i),
        .warp_pc_i(warp_pc_i),
        .warp_selected_o(warp_selected_o),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_pc_o(imem_req_pc_o),
        .imem_req_warp_o(imem_req_warp_o),
        .decode_done_i(decode_done_i),
        .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [PW-1:0] pc_of(input int w);
        return 32'hA000_0000 + 32'(w) * 32'h40;
    endfunction

    function automatic logic [NW-1:0] sel_of(input int w);
        logic [NW-1:0] one;
        one = 1;
        return one << w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_req(input string tag, input int w, input int infl);
        check({tag, " valid"}, 64'(imem_req_valid_o), 64'd1);
        check({tag, " warp"}, 64'(imem_req_warp_o), 64'(w));
        check({tag, " pc"}, 64'(imem_req_pc_o), 64'(pc_of(w)));
        check({tag, " inflight"}, 64'(inflight_o), 64'(infl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [3];
        order = '{2, 5, 7};

        for (int w = 0; w < NW; w++) warp_pc_i[w*PW +: PW] = pc_of(w);
        rst_i            = 1'b1;
        warp_ready_i     = '1;
        imem_req_ready_i = 1'b1;
        decode_done_i    = 1'b0;

        // 1: reset with every warp ready, then release
        tick();
        check("rst sel", 64'(warp_selected_o), 64'd0);
        check("rst valid", 64'(imem_req_valid_o), 64'd0);
        check("rst inflight", 64'(inflight_o), 64'd0);
        check("rst pc", 64'(imem_req_pc_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("release sel", 64'(warp_selected_o), 64'(sel_of(0)));
        tick();
        check_req("release req", 0, 1);
        warp_ready_i = '0;
        #1;
        check("idle sel", 64'(warp_selected_o), 64'd0);
        tick();
        check("idle valid", 64'(imem_req_valid_o), 64'd0);
        decode_done_i = 1'b1;
        tick();
        decode_done_i = 1'b0;
        check("retire inflight", 64'(inflight_o), 64'd0);

        // 2: round-robin among warps 2, 5 and 7 (pointer starts at 1)
        warp_ready_i = 8'hA4;
        for (int k = 0; k < 6; k++) begin
            decode_done_i = (k > 0);
            #1;
            check($sformatf("rr sel %0d", k), 64'(warp_selected_o), 64'(sel_of(order[k % 3])));
            tick();
            check_req($sformatf("rr req %0d", k), order[k % 3], 1);
        end
        warp_ready_i  = '0;
        decode_done_i = 1'b1;
        tick();
        decode_done_i = 1'b0;
        check("rr drain inflight", 64'(inflight_o), 64'd0);
        check("rr drain valid", 64'(imem_req_valid_o), 64'd0);

        // 3: backpressure (pointer at 0)
        warp_ready_i = 8'h08;
        #1;
        check("bp first sel", 64'(warp_selected_o), 64'(sel_of(3)));
        tick();
        check_req("bp first req", 3, 1);
        imem_req_ready_i = 1'b0;
        warp_ready_i     = 8'h11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp stall sel %0d", k), 64'(warp_selected_o), 64'd0);
            tick();
            check_req($sformatf("bp hold %0d", k), 3, 1);
        end
        imem_req_ready_i = 1'b1;
        #1;
        check("bp accept sel", 64'(warp_selected_o), 64'(sel_of(4)));
        tick();
        check_req("bp reload req", 4, 2);
        warp_ready_i  = '0;
        decode_done_i = 1'b1;
        tick();
        tick();
        decode_done_i = 1'b0;
        check("bp drain inflight", 64'(inflight_o), 64'd0);
        check("bp drain valid", 64'(imem_req_valid_o), 64'd0);

        // 4: credits (pointer at 5)
        warp_ready_i = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cr sel %0d", k), 64'(warp_selected_o), 64'(sel_of((5 + k) % NW)));
            tick();
            check_req($sformatf("cr req %0d", k), (5 + k) % NW, k + 1);
        end
        #1;
        check("cr full sel", 64'(warp_selected_o), 64'd0);
        tick();
        check("cr full inflight", 64'(inflight_o), 64'd4);
        check("cr full valid", 64'(imem_req_valid_o), 64'd0);
        decode_done_i = 1'b1;
        #1;
        check("cr no bypass sel", 64'(warp_selected_o), 64'd0);
        tick();
        decode_done_i = 1'b0;
        check("cr freed inflight", 64'(inflight_o), 64'd3);
        #1;
        check("cr one more sel", 64'(warp_selected_o), 64'(sel_of(1)));
        tick();
        check_req("cr one more req", 1, 4);
        #1;
        check("cr refull sel", 64'(warp_selected_o), 64'd0);
        decode_done_i = 1'b1;
        tick();
        check("cr pre-both inflight", 64'(inflight_o), 64'd3);
        #1;
        check("cr both sel", 64'(warp_selected_o), 64'(sel_of(2)));
        tick();
        check_req("cr both req", 2, 3);
        warp_ready_i = '0;
        tick();
        tick();
        tick();
        decode_done_i = 1'b0;
        check("cr drain inflight", 64'(inflight_o), 64'd0);

        // 5: reset in the middle of operation (pointer at 3)
        warp_ready_i = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_req($sformatf("mr req %0d", k), 3 + k, k + 1);
        end
        rst_i = 1'b1;
        #1;
        check("mr rst sel", 64'(warp_selected_o), 64'd0);
        tick();
        check("mr rst valid", 64'(imem_req_valid_o), 64'd0);
        check("mr rst inflight", 64'(inflight_o), 64'd0);
        check("mr rst warp", 64'(imem_req_warp_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("mr resume sel", 64'(warp_selected_o), 64'(sel_of(0)));
        tick();
        check_req("mr resume req", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
